// File: rtl/gpio_reg_bus_arbiter_if.sv
// Requester ports and GPIO register bus between the two masters and the arbiter.
// The slave modport is the arbiter's view; the master modport drives requests and register read data.
interface gpio_reg_bus_arbiter_if #(
    parameter int unsigned AddrWidth = 16,
    parameter int unsigned BusWidth  = 32
);
    logic                 m0_req;
    logic                 m0_we;
    logic [AddrWidth-3:0] m0_addr;
    logic [BusWidth-1:0]  m0_wdata;
    logic                 m0_ack;
    logic                 m0_err;
    logic [BusWidth-1:0]  m0_rdata;

    logic                 m1_req;
    logic                 m1_we;
    logic [AddrWidth-3:0] m1_addr;
    logic [BusWidth-1:0]  m1_wdata;
    logic                 m1_ack;
    logic                 m1_err;
    logic [BusWidth-1:0]  m1_rdata;

    logic                 chip_sel;
    logic                 write_reg;
    logic                 read_reg;
    logic [AddrWidth-3:0] busaddress;
    logic [BusWidth-1:0]  busdata_in;
    logic [BusWidth-1:0]  reg_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  reg_rdata,
        output m0_ack, m0_err, m0_rdata,
        output m1_ack, m1_err, m1_rdata,
        output chip_sel, write_reg, read_reg, busaddress, busdata_in
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output reg_rdata,
        input  m0_ack, m0_err, m0_rdata,
        input  m1_ack, m1_err, m1_rdata,
        input  chip_sel, write_reg, read_reg, busaddress, busdata_in
    );
endinterface

// File: rtl/gpio_reg_bus_arbiter.sv
// Round-robin arbiter sharing the GPIO register bus between the host (port 0) and a boot master (port 1).
//  state | meaning
//  IDLE  | arbitrate requests, latch the granted access
//  ISSUE | single-cycle chip_sel plus read or write strobe
//  WAIT  | turnaround countdown; read data captured on the last cycle
//  ACK   | one-cycle ack (with err for an out-of-window port-1 access)
module gpio_reg_bus_arbiter #(
    parameter int unsigned AddrWidth   = 16,
    parameter int unsigned BusWidth    = 32,
    parameter int unsigned ReadLatency = 4,
    parameter int unsigned WriteGap    = 2,
    parameter int unsigned WinLo       = 'h1100,
    parameter int unsigned WinHi       = 'h1400
) (
    input  logic                  reg_clk,
    input  logic                  reset_reg_N,
    gpio_reg_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

    localparam logic [3:0]           RdN     = 4'(ReadLatency);
    localparam logic [3:0]           WrN     = 4'(WriteGap);
    localparam logic [AddrWidth-1:0] WinLoB  = AddrWidth'(WinLo);
    localparam logic [AddrWidth-1:0] WinHiB  = AddrWidth'(WinHi);

    state_e               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 we_q, we_d;
    logic                 err_q, err_d;
    logic [AddrWidth-3:0] addr_q, addr_d;
    logic [BusWidth-1:0]  wdata_q, wdata_d;
    logic [BusWidth-1:0]  rdata_q, rdata_d;
    logic [3:0]           cnt_q, cnt_d;

    logic                 gnt_valid;
    logic                 gnt_port;
    logic                 m1_in_win;
    logic [AddrWidth-1:0] m1_byte_addr;
    logic [3:0]           wait_n;
    logic                 ack;

    assign m1_byte_addr = {bus.m1_addr, 2'b00};
    assign m1_in_win    = (m1_byte_addr >= WinLoB) && (m1_byte_addr < WinHiB);
    assign wait_n       = we_q ? WrN : RdN;

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        gnt_valid    = 1'b0;
        gnt_port     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // On contention the port that did not win last time is granted
                if (bus.m0_req && bus.m1_req) begin
                    gnt_valid = 1'b1;
                    gnt_port  = ~last_grant_q;
                end else if (bus.m0_req) begin
                    gnt_valid = 1'b1;
                    gnt_port  = 1'b0;
                end else if (bus.m1_req) begin
                    gnt_valid = 1'b1;
                    gnt_port  = 1'b1;
                end
                if (gnt_valid) begin
                    last_grant_d = gnt_port;
                    we_d         = gnt_port ? bus.m1_we    : bus.m0_we;
                    addr_d       = gnt_port ? bus.m1_addr  : bus.m0_addr;
                    wdata_d      = gnt_port ? bus.m1_wdata : bus.m0_wdata;
                    rdata_d      = '0;
                    err_d        = gnt_port && !m1_in_win;
                    state_d      = err_d ? ACK : ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = wait_n;
                state_d = (wait_n == 4'd0) ? ACK : WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = ACK;
                    if (!we_q) rdata_d = bus.reg_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack            = (state_q == ACK);
        bus.chip_sel   = (state_q == ISSUE);
        bus.write_reg  = (state_q == ISSUE) && we_q;
        bus.read_reg   = (state_q == ISSUE) && !we_q;
        bus.busaddress = addr_q;
        bus.busdata_in = wdata_q;
        bus.m0_ack     = ack && !last_grant_q;
        bus.m1_ack     = ack && last_grant_q;
        bus.m0_err     = 1'b0;
        bus.m1_err     = ack && last_grant_q && err_q;
        bus.m0_rdata   = (ack && !last_grant_q) ? rdata_q : '0;
        bus.m1_rdata   = (ack && last_grant_q) ? rdata_q : '0;
    end
endmodule

// File: tb/tb_gpio_reg_bus_arbiter.sv
// Directed bench for gpio_reg_bus_arbiter: default instance plus a WriteGap=0 instance for back-to-back writes.
module tb_gpio_reg_bus_arbiter;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    logic [13:0] bad_addr [2];

    gpio_reg_bus_arbiter_if #(.AddrWidth(16), .BusWidth(32)) bus0 ();
    gpio_reg_bus_arbiter_if #(.AddrWidth(16), .BusWidth(32)) bus1 ();

    gpio_reg_bus_arbiter #(
        .AddrWidth(16), .BusWidth(32), .ReadLatency(4), .WriteGap(2),
        .WinLo('h1100), .WinHi('h1400)
    ) dut (
        .reg_clk(clk), .reset_reg_N(rst_n), .bus(bus0)
    );

    gpio_reg_bus_arbiter #(
        .AddrWidth(16), .BusWidth(32), .ReadLatency(4), .WriteGap(0),
        .WinLo('h1100), .WinHi('h1400)
    ) dut_gap0 (
        .reg_clk(clk), .reset_reg_N(rst_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        bad_addr[0] = 14'h3FF;
        bad_addr[1] = 14'h500;
        rst_n = 1'b0;
        bus0.m0_req = 0; bus0.m0_we = 0; bus0.m0_addr = '0; bus0.m0_wdata = '0;
        bus0.m1_req = 0; bus0.m1_we = 0; bus0.m1_addr = '0; bus0.m1_wdata = '0;
        bus0.reg_rdata = '0;
        bus1.m0_req = 0; bus1.m0_we = 0; bus1.m0_addr = '0; bus1.m0_wdata = '0;
        bus1.m1_req = 0; bus1.m1_we = 0; bus1.m1_addr = '0; bus1.m1_wdata = '0;
        bus1.reg_rdata = '0;

        // Reset state
        #2;
        check("rst_chip_sel", bus0.chip_sel, 0);
        check("rst_acks", {bus0.m0_ack, bus0.m1_ack}, 0);
        check("rst_errs", {bus0.m0_err, bus0.m1_err}, 0);
        check("rst_busaddress", bus0.busaddress, 0);
        check("rst_busdata_in", bus0.busdata_in, 0);
        check("rst_rdata", {bus0.m0_rdata, bus0.m1_rdata}, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Contention right after reset: m0 first, then alternate while both held
        bus0.reg_rdata = 32'hA5A5_0000;
        bus0.m0_req = 1; bus0.m0_we = 0; bus0.m0_addr = 14'h440;
        bus0.m1_req = 1; bus0.m1_we = 0; bus0.m1_addr = 14'h448;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rr_addr_%0d", k), bus0.busaddress, (k % 2 == 0) ? 14'h440 : 14'h448);
            check($sformatf("rr_read_reg_%0d", k), bus0.read_reg, 1);
            repeat (5) tick();
            check($sformatf("rr_m0_ack_%0d", k), bus0.m0_ack, (k % 2 == 0) ? 1'b1 : 1'b0);
            check($sformatf("rr_m1_ack_%0d", k), bus0.m1_ack, (k % 2 == 1) ? 1'b1 : 1'b0);
            if (k == 3) begin
                bus0.m0_req = 0;
                bus0.m1_req = 0;
            end
            tick();
        end

        // m0 write at byte 0x1100, WriteGap=2
        bus0.m0_req = 1; bus0.m0_we = 1; bus0.m0_addr = 14'h440; bus0.m0_wdata = 32'h00FF_FFFF;
        tick();
        check("wr_chip_sel", bus0.chip_sel, 1);
        check("wr_write_reg", bus0.write_reg, 1);
        check("wr_read_reg", bus0.read_reg, 0);
        check("wr_busaddress", bus0.busaddress, 14'h440);
        check("wr_busdata_in", bus0.busdata_in, 32'h00FF_FFFF);
        tick();
        check("wr_strobe_drop", {bus0.chip_sel, bus0.write_reg}, 0);
        check("wr_addr_hold", bus0.busaddress, 14'h440);
        tick();
        check("wr_ack_early", bus0.m0_ack, 0);
        tick();
        check("wr_ack", {bus0.m0_ack, bus0.m1_ack, bus0.m0_err}, 3'b100);
        check("wr_rdata", bus0.m0_rdata, 0);
        bus0.m0_req = 0;
        tick();
        check("wr_ack_single", bus0.m0_ack, 0);

        // m1 read at byte 0x1120, data valid from c+5
        bus0.m1_req = 1; bus0.m1_we = 0; bus0.m1_addr = 14'h448;
        bus0.reg_rdata = 32'hDEAD_BEEF;
        tick();
        check("rd_strobes", {bus0.chip_sel, bus0.write_reg, bus0.read_reg}, 3'b101);
        check("rd_busaddress", bus0.busaddress, 14'h448);
        repeat (3) tick();
        check("rd_ack_early", bus0.m1_ack, 0);
        tick();
        bus0.reg_rdata = 32'h0302_0100;
        tick();
        check("rd_ack", {bus0.m1_ack, bus0.m0_ack, bus0.m1_err}, 3'b100);
        check("rd_rdata", bus0.m1_rdata, 32'h0302_0100);
        bus0.m1_req = 0;
        tick();

        // Out-of-window port-1 accesses at both window edges
        for (int i = 0; i < 2; i++) begin
            bus0.m1_req = 1; bus0.m1_we = 0; bus0.m1_addr = bad_addr[i];
            tick();
            check($sformatf("win_ack_err_%0d", i), {bus0.m1_ack, bus0.m1_err}, 2'b11);
            check($sformatf("win_rdata_%0d", i), bus0.m1_rdata, 0);
            check($sformatf("win_no_strobe_%0d", i), bus0.chip_sel, 0);
            bus0.m1_req = 0;
            tick();
            check($sformatf("win_idle_%0d", i), {bus0.chip_sel, bus0.m1_ack}, 0);
        end

        // Last in-window word (byte 0x13FC) is accepted
        bus0.m1_req = 1; bus0.m1_we = 1; bus0.m1_addr = 14'h4FF; bus0.m1_wdata = 32'h1234_5678;
        tick();
        check("win_top_strobe", {bus0.chip_sel, bus0.write_reg}, 2'b11);
        check("win_top_addr", bus0.busaddress, 14'h4FF);
        repeat (3) tick();
        check("win_top_ack", {bus0.m1_ack, bus0.m1_err}, 2'b10);
        bus0.m1_req = 0;
        tick();

        // Reset during WAIT of an m0 read
        bus0.m0_req = 1; bus0.m0_we = 0; bus0.m0_addr = 14'h440;
        bus0.reg_rdata = 32'h0BAD_F00D;
        tick();
        check("rst_mid_issue", bus0.read_reg, 1);
        tick();
        rst_n = 1'b0;
        bus0.m0_req = 0;
        #1;
        check("rst_mid_strobes", {bus0.chip_sel, bus0.read_reg, bus0.write_reg}, 0);
        check("rst_mid_acks", {bus0.m0_ack, bus0.m1_ack}, 0);
        check("rst_mid_addr", bus0.busaddress, 0);
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_rel_idle", {bus0.chip_sel, bus0.m0_ack}, 0);
        bus0.m0_req = 1; bus0.m0_we = 0; bus0.m0_addr = 14'h441;
        bus0.m1_req = 1; bus0.m1_we = 0; bus0.m1_addr = 14'h449;
        tick();
        check("rst_rel_m0_wins", bus0.busaddress, 14'h441);
        repeat (5) tick();
        check("rst_rel_ack", {bus0.m0_ack, bus0.m1_ack}, 2'b10);
        check("rst_rel_rdata", bus0.m0_rdata, 32'h0BAD_F00D);
        bus0.m0_req = 0;
        bus0.m1_req = 0;
        tick();

        // WriteGap=0 back-to-back writes with req held
        bus1.m0_req = 1; bus1.m0_we = 1; bus1.m0_addr = 14'h441; bus1.m0_wdata = 32'h1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("b2b_strobe_%0d", i), {bus1.chip_sel, bus1.write_reg, bus1.m0_ack}, 3'b110);
            check($sformatf("b2b_data_%0d", i), bus1.busdata_in, 32'h1000 + i);
            tick();
            check($sformatf("b2b_ack_%0d", i), {bus1.m0_ack, bus1.write_reg}, 2'b10);
            bus1.m0_wdata = 32'h1000 + i + 1;
            if (i == 2) bus1.m0_req = 0;
            tick();
            check($sformatf("b2b_gap_%0d", i), {bus1.write_reg, bus1.m0_ack}, 0);
        end
        tick();
        check("b2b_stop", bus1.chip_sel, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
